// File: rtl/rx_anc_phase_seq.sv
// rx_anc_phase_seq
// Programmable phase-hop sequencer for the DDS phase port in the RX ANC chain.
// A settings-bus-loaded table of phase increments is stepped through. Each entry
// is held for NSIG beats. Sweeps run one-shot or continuously, and the phase
// stream only advances on an AXI-Stream handshake.
//
// Ports
//   clk             single clock
//   reset_n         asynchronous active-low reset (also restores configuration)
//   srst            synchronous clear of sequencer state, configuration kept
//   set_stb/addr/data  settings bus write port
//   m_phase_tdata   phase beat to the DDS
//   m_phase_tvalid  phase beat valid
//   m_phase_tlast   last beat of a sweep
//   m_phase_tready  DDS ready
//   step_idx        table index of the presented beat
//   busy            sequencer in RUN or DRAIN
//   sweep_done      one-cycle pulse after the final beat of a one-shot sweep
module rx_anc_phase_seq #(
    parameter int unsigned PHASE_WIDTH  = 24,
    parameter int unsigned NCOUNT_WIDTH = 24,
    parameter int unsigned NUM_STEPS    = 8,
    parameter int unsigned SR_BASE      = 0,
    parameter int unsigned NSIG_DEF     = 32768,
    parameter int unsigned DPH_INC_DEF  = 4096,
    parameter int unsigned START_PH_DEF = 0,
    localparam int unsigned IDX_W       = $clog2(NUM_STEPS)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   srst,
    input  logic                   set_stb,
    input  logic [7:0]             set_addr,
    input  logic [31:0]            set_data,
    output logic [PHASE_WIDTH-1:0] m_phase_tdata,
    output logic                   m_phase_tvalid,
    output logic                   m_phase_tlast,
    input  logic                   m_phase_tready,
    output logic [IDX_W-1:0]       step_idx,
    output logic                   busy,
    output logic                   sweep_done
);

    localparam int unsigned NSTP_W = IDX_W + 1;

    localparam logic [7:0] ADDR_CTRL   = 8'(SR_BASE);
    localparam logic [7:0] ADDR_NSIG   = 8'(SR_BASE + 1);
    localparam logic [7:0] ADDR_START  = 8'(SR_BASE + 2);
    localparam logic [7:0] ADDR_TBL    = 8'(SR_BASE + 3);
    localparam logic [7:0] ADDR_NSTEPS = 8'(SR_BASE + 4);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Configuration registers
    logic [2:0]              ctrl_q;
    logic [NCOUNT_WIDTH-1:0] nsig_q;
    logic [PHASE_WIDTH-1:0]  start_ph_q;
    logic [NSTP_W-1:0]       nsteps_q;
    logic [PHASE_WIDTH-1:0]  inc_tbl_q [NUM_STEPS];

    // Sequencer state
    state_t                  state_q, state_d;
    logic [PHASE_WIDTH-1:0]  phase_q, phase_d;
    logic [NCOUNT_WIDTH-1:0] ncount_q, ncount_d;
    logic [IDX_W-1:0]        step_q, step_d;
    logic [PHASE_WIDTH-1:0]  inc_q, inc_d;
    logic                    bound_q, bound_d;
    logic                    last_q, last_d;
    logic                    valid_q, busy_q, done_q, done_d;

    logic                    wr_ctrl_c, wr_nsig_c, wr_start_c, wr_tbl_c, wr_nsteps_c;
    logic [IDX_W-1:0]        tbl_idx_c;
    logic [NCOUNT_WIDTH-1:0] nsig_eff_c;
    logic [NSTP_W-1:0]       nsteps_eff_c;
    logic [IDX_W-1:0]        last_step_c;
    logic [IDX_W-1:0]        step_nx_c;
    logic                    hs_c;
    logic                    unused_c;

    // Settings bus decode
    assign wr_ctrl_c   = set_stb && (set_addr == ADDR_CTRL);
    assign wr_nsig_c   = set_stb && (set_addr == ADDR_NSIG);
    assign wr_start_c  = set_stb && (set_addr == ADDR_START);
    assign wr_tbl_c    = set_stb && (set_addr == ADDR_TBL);
    assign wr_nsteps_c = set_stb && (set_addr == ADDR_NSTEPS);
    assign tbl_idx_c   = set_data[31 -: IDX_W];
    assign unused_c    = ^set_data;

    // NSIG of 0 behaves as 1; NSTEPS is forced into 1..NUM_STEPS
    assign nsig_eff_c = (nsig_q == '0) ? NCOUNT_WIDTH'(1) : nsig_q;

    always_comb begin
        nsteps_eff_c = nsteps_q;
        if (nsteps_q == '0) begin
            nsteps_eff_c = NSTP_W'(1);
        end else if (nsteps_q > NSTP_W'(NUM_STEPS)) begin
            nsteps_eff_c = NSTP_W'(NUM_STEPS);
        end
    end

    assign last_step_c = IDX_W'(nsteps_eff_c - NSTP_W'(1));
    assign hs_c        = valid_q && m_phase_tready;

    // Configuration register file, kept across srst
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q     <= '0;
            nsig_q     <= NCOUNT_WIDTH'(NSIG_DEF);
            start_ph_q <= PHASE_WIDTH'(START_PH_DEF);
            nsteps_q   <= NSTP_W'(1);
            for (int i = 0; i < int'(NUM_STEPS); i++) begin
                inc_tbl_q[i] <= PHASE_WIDTH'(DPH_INC_DEF);
            end
        end else begin
            if (wr_ctrl_c)   ctrl_q     <= set_data[2:0];
            if (wr_nsig_c)   nsig_q     <= set_data[NCOUNT_WIDTH-1:0];
            if (wr_start_c)  start_ph_q <= set_data[PHASE_WIDTH-1:0];
            if (wr_nsteps_c) nsteps_q   <= set_data[NSTP_W-1:0];
            if (wr_tbl_c)    inc_tbl_q[tbl_idx_c] <= set_data[PHASE_WIDTH-1:0];
        end
    end

    // Next-state and next-beat logic. bound/last flags describe the beat being
    // loaded, so tlast and the boundary decision never change during a stall.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        ncount_d  = ncount_q;
        step_d    = step_q;
        inc_d     = inc_q;
        bound_d   = bound_q;
        last_d    = last_q;
        done_d    = 1'b0;
        step_nx_c = last_q ? '0 : step_q + IDX_W'(1);

        unique case (state_q)
            ST_IDLE: begin
                if (wr_ctrl_c && set_data[0]) begin
                    state_d  = ST_RUN;
                    phase_d  = start_ph_q;
                    ncount_d = NCOUNT_WIDTH'(1);
                    step_d   = '0;
                    inc_d    = inc_tbl_q[IDX_W'(0)];
                    bound_d  = (nsig_eff_c == NCOUNT_WIDTH'(1));
                    last_d   = (nsig_eff_c == NCOUNT_WIDTH'(1)) && (last_step_c == '0);
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (hs_c) begin
                    if (bound_q) begin
                        ncount_d = NCOUNT_WIDTH'(1);
                        step_d   = step_nx_c;
                        inc_d    = inc_tbl_q[step_nx_c];
                        phase_d  = (ctrl_q[2] || last_q) ? start_ph_q : phase_q + inc_q;
                    end else begin
                        ncount_d = ncount_q + NCOUNT_WIDTH'(1);
                        phase_d  = phase_q + inc_q;
                    end
                    bound_d = (ncount_d >= nsig_eff_c);
                    last_d  = bound_d && (step_d >= last_step_c);

                    if (last_q && !ctrl_q[1]) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if ((state_q == ST_DRAIN) || (wr_ctrl_c && !set_data[0])) begin
                        state_d = ST_IDLE;
                    end
                end else if ((state_q == ST_RUN) && wr_ctrl_c && !set_data[0]) begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_IDLE) begin
            bound_d = 1'b0;
            last_d  = 1'b0;
        end

        // srst clears sequencer state; a coincident settings write still lands
        if (srst) begin
            state_d  = ST_IDLE;
            phase_d  = '0;
            ncount_d = '0;
            step_d   = '0;
            inc_d    = '0;
            bound_d  = 1'b0;
            last_d   = 1'b0;
            done_d   = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            ncount_q <= '0;
            step_q   <= '0;
            inc_q    <= '0;
            bound_q  <= 1'b0;
            last_q   <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            ncount_q <= ncount_d;
            step_q   <= step_d;
            inc_q    <= inc_d;
            bound_q  <= bound_d;
            last_q   <= last_d;
            valid_q  <= (state_d != ST_IDLE);
            busy_q   <= (state_d != ST_IDLE);
            done_q   <= done_d;
        end
    end

    assign m_phase_tdata  = phase_q;
    assign m_phase_tvalid = valid_q;
    assign m_phase_tlast  = last_q;
    assign step_idx       = step_q;
    assign busy           = busy_q;
    assign sweep_done     = done_q;

endmodule

// File: tb/tb_rx_anc_phase_seq.sv
// Testbench for rx_anc_phase_seq: scoreboard of expected phase beats built from
// a small behavioural model of the sweep, popped on every DUT handshake.
module tb_rx_anc_phase_seq;

    localparam int unsigned PW = 24;
    localparam int unsigned IW = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          srst = 1'b0;
    logic          set_stb = 1'b0;
    logic [7:0]    set_addr = '0;
    logic [31:0]   set_data = '0;
    logic [PW-1:0] m_phase_tdata;
    logic          m_phase_tvalid;
    logic          m_phase_tlast;
    logic          m_phase_tready = 1'b0;
    logic [IW-1:0] step_idx;
    logic          busy;
    logic          sweep_done;

    always #5 clk = ~clk;

    rx_anc_phase_seq #(
        .PHASE_WIDTH (24),
        .NCOUNT_WIDTH(24),
        .NUM_STEPS   (8),
        .SR_BASE     (0),
        .NSIG_DEF    (32768),
        .DPH_INC_DEF (4096),
        .START_PH_DEF(0)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .srst          (srst),
        .set_stb       (set_stb),
        .set_addr      (set_addr),
        .set_data      (set_data),
        .m_phase_tdata (m_phase_tdata),
        .m_phase_tvalid(m_phase_tvalid),
        .m_phase_tlast (m_phase_tlast),
        .m_phase_tready(m_phase_tready),
        .step_idx      (step_idx),
        .busy          (busy),
        .sweep_done    (sweep_done)
    );

    typedef struct packed {
        logic [PW-1:0] data;
        logic          last;
        logic [IW-1:0] idx;
    } beat_t;

    beat_t exp_q[$];
    int    n_assert = 0;
    int    n_fail   = 0;

    // Model of the configuration registers
    int            m_nsig;
    int            m_nsteps;
    logic [PW-1:0] m_start;
    logic [PW-1:0] m_tbl [8];
    bit            m_rps;

    // Stall tracking for the AXI hold rule
    bit            prv_stall = 1'b0;
    logic [PW-1:0] prv_data = '0;
    logic          prv_last = 1'b0;

    function automatic void reset_model();
        m_nsig   = 32768;
        m_nsteps = 1;
        m_start  = '0;
        m_rps    = 1'b0;
        for (int i = 0; i < 8; i++) m_tbl[i] = 24'd4096;
    endfunction

    // Expected beats for n complete sweeps from the model configuration
    function automatic void push_sweeps(int n);
        logic [PW-1:0] ph;
        beat_t         b;
        for (int k = 0; k < n; k++) begin
            ph = m_start;
            for (int s = 0; s < m_nsteps; s++) begin
                for (int c = 1; c <= m_nsig; c++) begin
                    b.data = ph;
                    b.last = (s == m_nsteps - 1) && (c == m_nsig);
                    b.idx  = IW'(s);
                    exp_q.push_back(b);
                    if (c == m_nsig && (m_rps || s == m_nsteps - 1)) ph = m_start;
                    else ph = ph + m_tbl[s];
                end
            end
        end
    endfunction

    // One clock: sample at negedge (scoreboard pop + stall hold), return at posedge+1
    task automatic step_clk();
        beat_t e;
        @(negedge clk);
        if (prv_stall) begin
            n_assert++;
            if (m_phase_tvalid !== 1'b1 || m_phase_tdata !== prv_data || m_phase_tlast !== prv_last) begin
                n_fail++;
                $display("FAIL stall_hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                         m_phase_tvalid, m_phase_tdata, m_phase_tlast, prv_data, prv_last);
            end
        end
        if (m_phase_tvalid === 1'b1 && m_phase_tready === 1'b1) begin
            n_assert++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: data=%h last=%b idx=%0d, required no beat",
                         m_phase_tdata, m_phase_tlast, step_idx);
            end else begin
                e = exp_q.pop_front();
                if (m_phase_tdata !== e.data || m_phase_tlast !== e.last || step_idx !== e.idx) begin
                    n_fail++;
                    $display("FAIL beat: data=%h last=%b idx=%0d, required data=%h last=%b idx=%0d",
                             m_phase_tdata, m_phase_tlast, step_idx, e.data, e.last, e.idx);
                end
            end
        end
        prv_stall = (m_phase_tvalid === 1'b1) && (m_phase_tready === 1'b0);
        prv_data  = m_phase_tdata;
        prv_last  = m_phase_tlast;
        @(posedge clk);
        #1;
    endtask

    task automatic sb_write(input logic [7:0] addr, input logic [31:0] data);
        set_stb  = 1'b1;
        set_addr = addr;
        set_data = data;
        step_clk();
        set_stb  = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input bit rnd, input string tag);
        int cyc = 0;
        while (exp_q.size() > 0 && cyc < budget) begin
            if (rnd) m_phase_tready = 1'($urandom_range(0, 1));
            step_clk();
            cyc++;
        end
        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d beats outstanding, required 0", tag, exp_q.size());
        end
    endtask

    task automatic cfg_hop();
        sb_write(8'd4, 32'd3);
        sb_write(8'd1, 32'd4);
        sb_write(8'd3, (32'd0 << 29) | 32'd100);
        sb_write(8'd3, (32'd1 << 29) | 32'd200);
        sb_write(8'd3, (32'd2 << 29) | 32'd300);
        sb_write(8'd2, 32'h10);
        m_nsteps = 3;
        m_nsig   = 4;
        m_tbl[0] = 24'd100;
        m_tbl[1] = 24'd200;
        m_tbl[2] = 24'd300;
        m_start  = 24'h10;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_assert++;
        if (m_phase_tdata !== '0 || m_phase_tvalid !== 1'b0 || m_phase_tlast !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_axis: data=%h valid=%b last=%b, required 0 0 0",
                     m_phase_tdata, m_phase_tvalid, m_phase_tlast);
        end
        n_assert++;
        if (step_idx !== '0 || busy !== 1'b0 || sweep_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: idx=%0d busy=%b done=%b, required 0 0 0",
                     step_idx, busy, sweep_done);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_default_sweep();
        m_phase_tready = 1'b1;
        push_sweeps(1);
        sb_write(8'd0, 32'h1);
        wait_drain(33000, 1'b0, "default");
        @(negedge clk);
        n_assert++;
        if (sweep_done !== 1'b1 || m_phase_tvalid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL default_done: done=%b valid=%b busy=%b, required 1 0 0",
                     sweep_done, m_phase_tvalid, busy);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_assert++;
        if (sweep_done !== 1'b0 || m_phase_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL default_after: done=%b valid=%b, required 0 0", sweep_done, m_phase_tvalid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_hop_reset_per_step();
        cfg_hop();
        m_rps = 1'b1;
        push_sweeps(1);
        sb_write(8'd0, 32'h5);
        wait_drain(100, 1'b0, "hop_rps");
        @(negedge clk);
        n_assert++;
        if (sweep_done !== 1'b1 || m_phase_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL hop_rps_done: done=%b valid=%b, required 1 0", sweep_done, m_phase_tvalid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_hop_accumulate();
        m_rps = 1'b0;
        push_sweeps(1);
        sb_write(8'd0, 32'h1);
        sb_write(8'd0, 32'h1);  // enable again while running must not restart
        wait_drain(100, 1'b0, "hop_acc");
        @(negedge clk);
        n_assert++;
        if (sweep_done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL hop_acc_done: done=%b busy=%b, required 1 0", sweep_done, busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap();
        sb_write(8'd4, 32'd1);
        sb_write(8'd1, 32'd3);
        sb_write(8'd2, 32'd0);
        sb_write(8'd3, (32'd0 << 29) | 32'h80_0000);
        m_nsteps = 1;
        m_nsig   = 3;
        m_start  = '0;
        m_tbl[0] = 24'h80_0000;
        push_sweeps(1);
        sb_write(8'd0, 32'h1);
        wait_drain(50, 1'b0, "wrap");
        @(negedge clk);
        n_assert++;
        if (sweep_done !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_done: done=%b, required 1", sweep_done);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_throttle_drain();
        cfg_hop();
        m_rps = 1'b1;
        push_sweeps(3);
        m_phase_tready = 1'b1;
        sb_write(8'd0, 32'h7);
        wait_drain(2000, 1'b1, "throttle");
        // next continuous beat is now presented; stall it and disable
        m_phase_tready = 1'b0;
        sb_write(8'd0, 32'h6);
        repeat (3) step_clk();
        n_assert++;
        if (busy !== 1'b1 || m_phase_tvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_hold: busy=%b valid=%b, required 1 1", busy, m_phase_tvalid);
        end
        exp_q.push_back('{data: 24'h10, last: 1'b0, idx: 3'd0});
        m_phase_tready = 1'b1;
        step_clk();
        n_assert++;
        if (busy !== 1'b0 || m_phase_tvalid !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_exit: busy=%b valid=%b pending=%0d, required 0 0 0",
                     busy, m_phase_tvalid, exp_q.size());
        end
    endtask

    task automatic test_srst();
        m_phase_tready = 1'b1;
        push_sweeps(1);
        sb_write(8'd0, 32'h5);
        repeat (5) step_clk();
        srst     = 1'b1;
        set_stb  = 1'b1;
        set_addr = 8'd2;
        set_data = 32'h20;
        step_clk();
        srst    = 1'b0;
        set_stb = 1'b0;
        exp_q.delete();
        n_assert++;
        if (m_phase_tvalid !== 1'b0 || busy !== 1'b0 || m_phase_tdata !== '0 ||
            step_idx !== '0 || m_phase_tlast !== 1'b0 || sweep_done !== 1'b0) begin
            n_fail++;
            $display("FAIL srst_clear: valid=%b busy=%b data=%h idx=%0d last=%b done=%b, required all 0",
                     m_phase_tvalid, busy, m_phase_tdata, step_idx, m_phase_tlast, sweep_done);
        end
        m_start = 24'h20;
        push_sweeps(1);
        sb_write(8'd0, 32'h5);
        wait_drain(100, 1'b0, "srst_rerun");
        @(negedge clk);
        n_assert++;
        if (sweep_done !== 1'b1) begin
            n_fail++;
            $display("FAIL srst_rerun_done: done=%b, required 1", sweep_done);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_n();
        m_phase_tready = 1'b1;
        push_sweeps(1);
        sb_write(8'd0, 32'h7);
        repeat (4) step_clk();
        #2;
        reset_n = 1'b0;
        #1;
        n_assert++;
        if (m_phase_tvalid !== 1'b0 || busy !== 1'b0 || m_phase_tdata !== '0 ||
            step_idx !== '0 || m_phase_tlast !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b busy=%b data=%h idx=%0d last=%b, required all 0",
                     m_phase_tvalid, busy, m_phase_tdata, step_idx, m_phase_tlast);
        end
        exp_q.delete();
        prv_stall = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        reset_model();
        sb_write(8'd1, 32'd4);
        m_nsig = 4;
        push_sweeps(1);
        sb_write(8'd0, 32'h1);
        wait_drain(100, 1'b0, "post_reset");
        @(negedge clk);
        n_assert++;
        if (sweep_done !== 1'b1 || m_phase_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_done: done=%b valid=%b, required 1 0", sweep_done, m_phase_tvalid);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        test_reset();
        test_default_sweep();
        test_hop_reset_per_step();
        test_hop_accumulate();
        test_wrap();
        test_throttle_drain();
        test_srst();
        test_reset_n();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
